// File: rtl/axi_redirect_ctrl.sv
// axi_redirect_ctrl
// Sequences a change of the redirect/swap mapping used by the AR/AW address
// decoders. New address acceptance is stalled, the read and write outstanding
// counters are allowed to drain, the mapping is updated in one cycle and the
// stall is released together with the completion acknowledge.
module axi_redirect_ctrl #(
    parameter int N_INIT_PORT = 8,
    parameter int LOG_N_INIT  = 3,
    parameter int TIMEOUT     = 1024,
    parameter int TMR_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_req_i,
    input  logic                  cfg_enable_i,
    input  logic [LOG_N_INIT-1:0] cfg_source_i,
    input  logic [LOG_N_INIT-1:0] cfg_target_i,
    output logic                  cfg_ack_o,
    output logic                  cfg_err_o,
    output logic                  stall_o,
    input  logic                  ar_outstanding_i,
    input  logic                  aw_outstanding_i,
    output logic [LOG_N_INIT-1:0] source_r_o,
    output logic [LOG_N_INIT-1:0] target_r_o,
    output logic                  redirect_valid_r_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  state_s;
    logic [TMR_W-1:0]        timer_r;
    logic [TMR_W-1:0]        timer_s;
    logic                    err_r;
    logic                    err_s;
    logic                    latch_s;
    logic                    req_invalid_s;
    logic                    drained_s;
    logic                    en_lat_r;
    logic [LOG_N_INIT-1:0]   src_lat_r;
    logic [LOG_N_INIT-1:0]   tgt_lat_r;
    logic [LOG_N_INIT-1:0]   source_r;
    logic [LOG_N_INIT-1:0]   target_r;
    logic                    valid_r;

    // An enable request must name two distinct, existing ports; disables are always accepted.
    always_comb begin
        req_invalid_s = 1'b0;
        if (cfg_enable_i) begin
            req_invalid_s = (cfg_source_i == cfg_target_i)
                         || (int'(cfg_source_i) >= N_INIT_PORT)
                         || (int'(cfg_target_i) >= N_INIT_PORT);
        end else begin
            req_invalid_s = 1'b0;
        end
    end

    // Drain is trusted only from the second stalled cycle, after any in-flight handshake has been counted.
    always_comb begin
        drained_s = (timer_r != TMR_ZERO) && !ar_outstanding_i && !aw_outstanding_i;
    end

    // Next-state, timer and error-flag logic for the sequencer.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        err_s   = err_r;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_req_i) begin
                    if (req_invalid_s) begin
                        err_s   = 1'b1;
                        state_s = RESP;
                    end else begin
                        err_s   = 1'b0;
                        latch_s = 1'b1;
                        timer_s = TMR_ZERO;
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (timer_r != TMR_MAX) begin
                    timer_s = timer_r + TMR_ONE;
                end else begin
                    timer_s = timer_r;
                end
                if (drained_s) begin
                    state_s = APPLY;
                end else if (timer_r == TMR_MAX) begin
                    err_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = DRAIN;
                end
            end
            APPLY: begin
                err_s   = 1'b0;
                state_s = RESP;
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state, drain timer, error flag and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            timer_r   <= TMR_ZERO;
            err_r     <= 1'b0;
            en_lat_r  <= 1'b0;
            src_lat_r <= {LOG_N_INIT{1'b0}};
            tgt_lat_r <= {LOG_N_INIT{1'b0}};
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            err_r   <= err_s;
            if (latch_s) begin
                en_lat_r  <= cfg_enable_i;
                src_lat_r <= cfg_source_i;
                tgt_lat_r <= cfg_target_i;
            end
        end
    end

    // Mapping registers change only while in APPLY, so only under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            source_r <= {LOG_N_INIT{1'b0}};
            target_r <= {LOG_N_INIT{1'b0}};
            valid_r  <= 1'b0;
        end else if (state_r == APPLY) begin
            if (en_lat_r) begin
                source_r <= src_lat_r;
                target_r <= tgt_lat_r;
                valid_r  <= 1'b1;
            end else begin
                valid_r  <= 1'b0;
            end
        end
    end

    assign stall_o            = (state_r == DRAIN) || (state_r == APPLY);
    assign cfg_ack_o          = (state_r == RESP);
    assign cfg_err_o          = (state_r == RESP) && err_r;
    assign busy_o             = (state_r != IDLE);
    assign source_r_o         = source_r;
    assign target_r_o         = target_r;
    assign redirect_valid_r_o = valid_r;

endmodule

// File: tb/tb_axi_redirect_ctrl.sv
// Self-checking bench for axi_redirect_ctrl: transaction-level timing model
// compared every cycle, directed scenarios with literal expectations, then
// randomized requests and outstanding-counter activity.
module tb_axi_redirect_ctrl;

    localparam int NP   = 6;
    localparam int LOGN = 3;
    localparam int TO   = 16;
    localparam int TW   = 16;

    logic            clk;
    logic            rst_n;
    logic            cfg_req;
    logic            cfg_enable;
    logic [LOGN-1:0] cfg_source;
    logic [LOGN-1:0] cfg_target;
    logic            cfg_ack;
    logic            cfg_err;
    logic            stall;
    logic            ar_out;
    logic            aw_out;
    logic [LOGN-1:0] src_r;
    logic [LOGN-1:0] tgt_r;
    logic            valid_r;
    logic            busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    axi_redirect_ctrl #(
        .N_INIT_PORT(NP), .LOG_N_INIT(LOGN), .TIMEOUT(TO), .TMR_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_req_i(cfg_req), .cfg_enable_i(cfg_enable),
        .cfg_source_i(cfg_source), .cfg_target_i(cfg_target),
        .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err), .stall_o(stall),
        .ar_outstanding_i(ar_out), .aw_outstanding_i(aw_out),
        .source_r_o(src_r), .target_r_o(tgt_r),
        .redirect_valid_r_o(valid_r), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: age counts cycles since the request was accepted;
    // ack_age is the age of the acknowledge cycle once it is known (-1 before).
    typedef struct packed {
        bit        active;
        bit        okreq;
        bit        err;
        bit        en;
        int        age;
        int        ack_age;
        bit [2:0]  lsrc;
        bit [2:0]  ltgt;
        bit [2:0]  src;
        bit [2:0]  tgt;
        bit        valid;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, bit req, bit en, bit [2:0] s,
                                          bit [2:0] t, bit ar, bit aw);
        model_t n = cur;
        if (!n.active) begin
            if (req) begin
                n.active  = 1'b1;
                n.age     = 0;
                n.en      = en;
                n.lsrc    = s;
                n.ltgt    = t;
                n.okreq   = !(en && (s == t || int'(s) >= NP || int'(t) >= NP));
                n.err     = !n.okreq;
                n.ack_age = n.okreq ? -1 : 1;
            end
        end else begin
            if (n.okreq && n.ack_age < 0) begin
                if (n.age >= 2 && !ar && !aw) begin
                    n.ack_age = n.age + 2;
                end else if (n.age == TO + 1) begin
                    n.ack_age = n.age + 1;
                    n.err     = 1'b1;
                end
            end
            if (n.okreq && !n.err && n.age == n.ack_age - 1) begin
                if (n.en) begin
                    n.src   = n.lsrc;
                    n.tgt   = n.ltgt;
                    n.valid = 1'b1;
                end else begin
                    n.valid = 1'b0;
                end
            end
            if (n.age == n.ack_age) n.active = 1'b0;
        end
        if (n.active) n.age = n.age + 1;
        return n;
    endfunction

    function automatic logic [10:0] model_out(model_t cur);
        bit a, e, s;
        a = cur.active && (cur.age == cur.ack_age);
        e = a && cur.err;
        s = cur.active && cur.okreq && cur.age >= 1 && (cur.ack_age < 0 || cur.age < cur.ack_age);
        return {a, e, s, cur.active, cur.src, cur.tgt, cur.valid};
    endfunction

    // Reference model advances on the same edge as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, cfg_req, cfg_enable, cfg_source, cfg_target, ar_out, aw_out);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [10:0] got;
        logic [10:0] exp;
        if (cmp_en) begin
            got = {cfg_ack, cfg_err, stall, busy, src_r, tgt_r, valid_r};
            exp = model_out(m);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t {ack,err,stall,busy,src,tgt,valid} got=%b exp=%b",
                         $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Issue one request; ar/aw are held high for the first ar_hold/aw_hold
    // cycles counting the cycle in which the request is first sampled.
    task automatic run_req(input bit en, input int s, input int t, input int ar_hold,
                           input int aw_hold, output int lat, output bit err, output bit saw_stall);
        int c;
        @(negedge clk);
        cfg_enable = en;
        cfg_source = LOGN'(s);
        cfg_target = LOGN'(t);
        cfg_req    = 1'b1;
        ar_out     = (0 < ar_hold);
        aw_out     = (0 < aw_hold);
        lat        = -1;
        err        = 1'b0;
        saw_stall  = 1'b0;
        c          = 0;
        while (c < 100 && lat < 0) begin
            @(negedge clk);
            c++;
            if (stall) saw_stall = 1'b1;
            if (cfg_ack) begin
                lat = c;
                err = cfg_err;
            end else begin
                ar_out = (c < ar_hold);
                aw_out = (c < aw_hold);
            end
        end
        cfg_req = 1'b0;
        ar_out  = 1'b0;
        aw_out  = 1'b0;
        if (lat < 0) chk("ack_wait_expired", 32'd1, 32'd0);
    endtask

    initial begin
        int lat;
        bit err;
        bit sst;
        int mode;
        rst_n = 1'b0; cfg_req = 1'b0; cfg_enable = 1'b0;
        cfg_source = '0; cfg_target = '0; ar_out = 1'b0; aw_out = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("reset_outputs", {cfg_ack, cfg_err, stall, busy, src_r, tgt_r, valid_r}, 32'd0);

        // Install 2->5 with nothing outstanding: best-case latency.
        run_req(1'b1, 2, 5, 0, 0, lat, err, sst);
        chk("install_lat", lat, 4);
        chk("install_err", err, 0);
        chk("install_map", {src_r, tgt_r, valid_r}, {3'd2, 3'd5, 1'b1});

        // Read counter busy for ten cycles.
        run_req(1'b1, 3, 0, 10, 0, lat, err, sst);
        chk("drain_lat", lat, 12);
        chk("drain_err", err, 0);
        chk("drain_map", {src_r, tgt_r, valid_r}, {3'd3, 3'd0, 1'b1});

        // Write counter stuck: timeout, old mapping kept.
        run_req(1'b1, 1, 4, 0, 1000, lat, err, sst);
        chk("timeout_lat", lat, TO + 2);
        chk("timeout_err", err, 1);
        chk("timeout_map", {src_r, tgt_r, valid_r}, {3'd3, 3'd0, 1'b1});
        chk("timeout_stall_released", stall, 0);

        // Counter clears exactly on the timeout cycle: success wins.
        run_req(1'b1, 1, 4, 0, TO + 1, lat, err, sst);
        chk("edge_lat", lat, TO + 3);
        chk("edge_err", err, 0);
        chk("edge_map", {src_r, tgt_r, valid_r}, {3'd1, 3'd4, 1'b1});

        // Invalid requests: same port, and port index out of range.
        run_req(1'b1, 3, 3, 0, 0, lat, err, sst);
        chk("inv_same_lat", lat, 1);
        chk("inv_same_err", err, 1);
        chk("inv_same_nostall", sst, 0);
        run_req(1'b1, 7, 2, 0, 0, lat, err, sst);
        chk("inv_range_lat", lat, 1);
        chk("inv_range_err", err, 1);
        chk("inv_range_nostall", sst, 0);
        chk("inv_map", {src_r, tgt_r, valid_r}, {3'd1, 3'd4, 1'b1});

        // Install then disable (disable with equal fields is still valid).
        run_req(1'b1, 2, 5, 0, 0, lat, err, sst);
        run_req(1'b0, 0, 0, 0, 0, lat, err, sst);
        chk("disable_lat", lat, 4);
        chk("disable_err", err, 0);
        chk("disable_map", {src_r, tgt_r, valid_r}, {3'd2, 3'd5, 1'b0});

        // Asynchronous reset while draining.
        @(negedge clk);
        cfg_enable = 1'b1; cfg_source = 3'd0; cfg_target = 3'd1; cfg_req = 1'b1; ar_out = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_stall", stall, 1);
        #2;
        rst_n   = 1'b0;
        cfg_req = 1'b0;
        ar_out  = 1'b0;
        #1;
        chk("reset_mid_outputs", {cfg_ack, cfg_err, stall, busy, src_r, tgt_r, valid_r}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b1, 4, 1, 0, 0, lat, err, sst);
        chk("post_reset_lat", lat, 4);
        chk("post_reset_map", {src_r, tgt_r, valid_r}, {3'd4, 3'd1, 1'b1});

        // Randomized traffic, checked every cycle by the model.
        mode = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cfg_req && cfg_ack) begin
                cfg_req = 1'b0;
            end else if (!cfg_req && $urandom_range(0, 3) == 0) begin
                cfg_enable = ($urandom_range(0, 4) != 0);
                cfg_source = LOGN'($urandom_range(0, 7));
                cfg_target = LOGN'($urandom_range(0, 7));
                mode       = int'($urandom_range(0, 4));
                cfg_req    = 1'b1;
            end
            case (mode)
                0: begin ar_out = 1'b0; aw_out = 1'b0; end
                1: begin ar_out = ($urandom_range(0, 9) < 3); aw_out = ($urandom_range(0, 9) < 3); end
                2: begin ar_out = ($urandom_range(0, 9) < 8); aw_out = ($urandom_range(0, 9) < 2); end
                3: begin ar_out = 1'b0; aw_out = 1'b1; end
                default: begin ar_out = ($urandom_range(0, 19) != 0); aw_out = 1'b0; end
            endcase
        end
        cfg_req = 1'b0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
